line_fill_engine: RTL

- Memory-side stage directly downstream of the direct-mapped cache.
- Accepts one whole-line command from the cache: a fill (load) or a writeback (store).
- Serialises the command into a single-address, multi-beat burst on the DATA_WIDTH memory bus.
- For a fill, reassembles the beats into a line and returns it to the cache through a valid/ready response.

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/line_buffer.sv | 36 +++
 rtl/line_fill_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and width helpers for the cache-to-memory line transfer path.
package mem_bus_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, WRITE, WACK, READ, RESP} state_t;

   localparam int DEFAULT_DATA_WIDTH = 64;
   localparam int WORD_BYTES = DEFAULT_DATA_WIDTH / 8;

   function automatic int beat_cnt_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int line_off_w(input int line_words, input int data_width);
      return $clog2(line_words * data_width / 8);
   endfunction

   function automatic int beat_off_w(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One cache line of storage: whole-line load, single-word write/read, whole-line view.
module line_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int LINE_WORDS = 32,
   parameter int IDX_W      = 5
) (
   input  logic                             clk,
   input  logic                             load_en,
   input  logic [DATA_WIDTH*LINE_WORDS-1:0] load_line,
   input  logic                             wr_en,
   input  logic [IDX_W-1:0]                 wr_idx,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [IDX_W-1:0]                 rd_idx,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic [DATA_WIDTH*LINE_WORDS-1:0] line
);

   logic [DATA_WIDTH-1:0] words [LINE_WORDS];

   always_ff @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            words[i] <= load_line[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end else if (wr_en) begin
         words[wr_idx] <= wr_data;
      end
   end

   assign rd_data = words[rd_idx];

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
      assign line[g*DATA_WIDTH +: DATA_WIDTH] = words[g];
   end

endmodule

// File: rtl/line_fill_engine.sv
// Turns one whole-line fill/writeback command into a single-address memory burst.
// Optional CRITICAL_WORD_FIRST_EN: fills start at the requested beat with a wrapping burst.
module line_fill_engine
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int LINE_WORDS = 32
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    cmd_valid,
   output logic                                    cmd_ready,
   input  logic                                    cmd_store,
   input  logic [ADDR_WIDTH-1:0]                   cmd_addr,
   input  logic [DATA_WIDTH*LINE_WORDS-1:0]        cmd_wline,
   output logic                                    resp_valid,
   input  logic                                    resp_ready,
   output logic [DATA_WIDTH*LINE_WORDS-1:0]        resp_rline,
   output logic                                    mem_avalid,
   input  logic                                    mem_aready,
   output logic                                    mem_awrite,
   output logic [ADDR_WIDTH-1:0]                   mem_aaddr,
   output logic [$clog2(LINE_WORDS)-1:0]           mem_alen,
   output logic                                    mem_awrap,
   output logic                                    mem_wvalid,
   input  logic                                    mem_wready,
   output logic [DATA_WIDTH-1:0]                   mem_wdata,
   output logic                                    mem_wlast,
   input  logic                                    mem_rvalid,
   output logic                                    mem_rready,
   input  logic [DATA_WIDTH-1:0]                   mem_rdata,
   input  logic                                    mem_rlast,
   input  logic                                    mem_bvalid,
   output logic                                    mem_bready,
   output logic                                    err
);

   localparam int CW = beat_cnt_w(LINE_WORDS);
   localparam int OW = line_off_w(LINE_WORDS, DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OW) - 64'd1);
`ifdef CRITICAL_WORD_FIRST_EN
   localparam int BW = beat_off_w(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'((64'd1 << BW) - 64'd1);
`endif

   state_t                  state, state_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic [CW-1:0]           start_q, start_n;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
   logic                    store_q, store_n;
   logic                    err_q, err_n;
   logic                    rdy_q;
   logic                    load_en, wr_en;
   logic [CW-1:0]           wr_idx;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [DATA_WIDTH*LINE_WORDS-1:0] line;

   line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .LINE_WORDS(LINE_WORDS),
      .IDX_W     (CW)
   ) u_buf (
      .clk      (clk),
      .load_en  (load_en),
      .load_line(cmd_wline),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (mem_rdata),
      .rd_idx   (cnt),
      .rd_data  (rd_data),
      .line     (line)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         start_q <= '0;
         addr_q  <= '0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         start_q <= start_n;
         addr_q  <= addr_n;
         store_q <= store_n;
         err_q   <= err_n;
         rdy_q   <= (state_n == IDLE);
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      start_n    = start_q;
      addr_n     = addr_q;
      store_n    = store_q;
      err_n      = err_q;
      load_en    = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = start_q + cnt;
      mem_avalid = 1'b0;
      mem_awrite = 1'b0;
      mem_aaddr  = '0;
      mem_alen   = '0;
      mem_awrap  = 1'b0;
      mem_wvalid = 1'b0;
      mem_wdata  = '0;
      mem_wlast  = 1'b0;
      mem_rready = 1'b0;
      mem_bready = 1'b0;
      resp_valid = 1'b0;
      resp_rline = '0;
      unique case (state)
         IDLE: begin
            if (cmd_valid && rdy_q) begin
               load_en = 1'b1;
               store_n = cmd_store;
               addr_n  = cmd_addr & LINE_MASK;
               start_n = '0;
`ifdef CRITICAL_WORD_FIRST_EN
               if (!cmd_store) begin
                  addr_n  = cmd_addr & BEAT_MASK;
                  start_n = cmd_addr[OW-1 -: CW];
               end
`endif
               state_n = ADDR;
            end
         end
         ADDR: begin
            mem_avalid = 1'b1;
            mem_awrite = store_q;
            mem_aaddr  = addr_q;
            mem_alen   = LAST;
`ifdef CRITICAL_WORD_FIRST_EN
            mem_awrap  = !store_q;
`endif
            if (mem_aready) begin
               cnt_n   = '0;
               state_n = store_q ? WRITE : READ;
            end
         end
         WRITE: begin
            mem_wvalid = 1'b1;
            mem_wdata  = rd_data;
            mem_wlast  = (cnt == LAST);
            if (mem_wready) begin
               cnt_n = cnt + 1'b1;
               if (cnt == LAST) state_n = WACK;
            end
         end
         WACK: begin
            mem_bready = 1'b1;
            if (mem_bvalid) state_n = RESP;
         end
         READ: begin
            mem_rready = 1'b1;
            // Completion follows the beat count; rlast is only cross-checked against it.
            if (mem_rvalid) begin
               wr_en = 1'b1;
               cnt_n = cnt + 1'b1;
               if (mem_rlast != (cnt == LAST)) err_n = 1'b1;
               if (cnt == LAST) state_n = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rline = line;
            if (resp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign cmd_ready = rdy_q;
   assign err       = err_q;

endmodule
